// File: rtl/block_multiply_pkg.sv
// Shared constants for the block_multiply tile multiplier: default tile geometry,
// fixed-point format, FSM state encodings and the row-major element index helper.
package block_multiply_pkg;

  // Default tile geometry and number format, shared with the rest of the matmul datapath
  localparam int BM_DATA_W = 16;
  localparam int BM_J      = 2;
  localparam int BM_K      = 2;
  localparam int BM_FRAC_W = 0;
  localparam int BM_SAT    = 1;

  // FSM encodings kept as plain constants so older tooling can share them
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_LAST = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Row-major element index: element (row, col) of a matrix with ncols columns
  function automatic int rm_idx(input int row, input int col, input int ncols);
    return row * ncols + col;
  endfunction

endpackage

// File: rtl/block_multiply_if.sv
// Request/operand/result bundle between the matrix_mul controller and block_multiply.
interface block_multiply_if import block_multiply_pkg::*; #(
  parameter int DATA_W = BM_DATA_W,
  parameter int J      = BM_J,
  parameter int K      = BM_K
) ();

  logic                    start;
  logic [J*K*DATA_W-1:0]   block_a;
  logic [K*J*DATA_W-1:0]   block_b;
  logic [J*J*DATA_W-1:0]   block_c;
  logic                    busy;
  logic                    done;
  logic                    overflow;

  modport master (
    output start, block_a, block_b,
    input  block_c, busy, done, overflow
  );

  modport slave (
    input  start, block_a, block_b,
    output block_c, busy, done, overflow
  );

endinterface

// File: rtl/block_multiply_mac_unit.sv
// Signed multiply-accumulate with clear, arithmetic right shift and narrowing
// (saturate or wrap). The narrowed result and overflow flag reflect the value
// being loaded into the accumulator on this edge, so the caller can store the
// finished dot product in the same edge as its last product.
module mac_unit #(
  parameter int DATA_W = 16,
  parameter int K      = 2,
  parameter int FRAC_W = 0,
  parameter int SAT    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic                     clear_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic        [DATA_W-1:0] res_o,
  output logic                     ovf_o
);

  localparam int PROD_W = 2 * DATA_W;
  // Headroom for K products plus one guard bit: the accumulator can never overflow
  localparam int ACC_W  = PROD_W + $clog2(K) + 1;

  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  acc_base;
  logic signed [ACC_W-1:0]  shifted;
  logic                     too_high;
  logic                     too_low;

  assign prod = a_i * b_i;

  // Next accumulator value, scaled and range-checked against the element format
  always_comb begin
    acc_base = clear_i ? '0 : acc_q;
    acc_d    = acc_base + ACC_W'(prod);
    shifted  = acc_d >>> FRAC_W;
    too_high = shifted > MAX_V;
    too_low  = shifted < MIN_V;
    ovf_o    = too_high || too_low;
    res_o    = shifted[DATA_W-1:0];
    if (SAT != 0 && too_high) begin
      res_o = MAX_V[DATA_W-1:0];
    end else if (SAT != 0 && too_low) begin
      res_o = MIN_V[DATA_W-1:0];
    end
  end

  // Accumulator register, only advanced while a product is being issued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/block_multiply.sv
// J x K by K x J tile multiplier: captures both operand tiles on accept, walks
// (row, col, k) issuing one product per cycle to mac_unit, stores each finished
// element into the result register file, then holds done until start drops.
module block_multiply import block_multiply_pkg::*; #(
  parameter int DATA_W = BM_DATA_W,
  parameter int J      = BM_J,
  parameter int K      = BM_K,
  parameter int FRAC_W = BM_FRAC_W,
  parameter int SAT    = BM_SAT
) (
  input  logic           clk,
  input  logic           rst,
  block_multiply_if.slave bus
);

  localparam int RC_W = $clog2(J) + 1;
  localparam int KC_W = $clog2(K) + 1;
  localparam int A_W  = J * K * DATA_W;
  localparam int B_W  = K * J * DATA_W;

  localparam logic [RC_W-1:0] RC_LAST = RC_W'(J - 1);
  localparam logic [KC_W-1:0] K_LAST  = KC_W'(K - 1);

  logic [1:0]        state_q, state_d;
  logic [RC_W-1:0]   row_q, row_d;
  logic [RC_W-1:0]   col_q, col_d;
  logic [KC_W-1:0]   k_q, k_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic [A_W-1:0]    a_q, a_d;
  logic [B_W-1:0]    b_q, b_d;

  logic              mac_en;
  logic              mac_clr;
  logic              c_wr;
  logic [DATA_W-1:0] a_sel;
  logic [DATA_W-1:0] b_sel;
  logic [DATA_W-1:0] mac_res;
  logic              mac_ovf;
  int                a_idx;
  int                b_idx;
  int                c_idx;

  logic [DATA_W-1:0] c_q [J*J];

  // Pick a[row][k] and b[k][col] out of the captured tiles
  always_comb begin
    a_idx = rm_idx(int'(row_q), int'(k_q), K);
    b_idx = rm_idx(int'(k_q), int'(col_q), J);
    c_idx = rm_idx(int'(row_q), int'(col_q), J);
    a_sel = '0;
    b_sel = '0;
    for (int e = 0; e < J * K; e++) begin
      if (e == a_idx) a_sel = a_q[e*DATA_W +: DATA_W];
      if (e == b_idx) b_sel = b_q[e*DATA_W +: DATA_W];
    end
  end

  mac_unit #(
    .DATA_W (DATA_W),
    .K      (K),
    .FRAC_W (FRAC_W),
    .SAT    (SAT)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .en_i    (mac_en),
    .clear_i (mac_clr),
    .a_i     (a_sel),
    .b_i     (b_sel),
    .res_o   (mac_res),
    .ovf_o   (mac_ovf)
  );

  // Sequencer: accept, k/col/row walk, one settle cycle, then hold done for the requester
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    k_d     = k_q;
    busy_d  = busy_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    a_d     = a_q;
    b_d     = b_q;
    mac_en  = 1'b0;
    mac_clr = 1'b0;
    c_wr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d     = bus.block_a;
          b_d     = bus.block_b;
          row_d   = '0;
          col_d   = '0;
          k_d     = '0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        mac_en  = 1'b1;
        mac_clr = (k_q == '0);
        if (k_q == K_LAST) begin
          c_wr = 1'b1;
          if (mac_ovf) ovf_d = 1'b1;
          k_d = '0;
          if (col_q == RC_LAST) begin
            col_d = '0;
            if (row_q == RC_LAST) begin
              row_d   = '0;
              state_d = ST_LAST;
            end else begin
              row_d = row_q + RC_W'(1);
            end
          end else begin
            col_d = col_q + RC_W'(1);
          end
        end else begin
          k_d = k_q + KC_W'(1);
        end
      end
      ST_LAST: begin
        // The last element landed on the previous edge; publish completion now
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!bus.start) begin
          done_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and operand-capture registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // Result register file: each element keeps its old value until its own write
  for (genvar gi = 0; gi < J * J; gi++) begin : g_c
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        c_q[gi] <= '0;
      end else if (c_wr && c_idx == gi) begin
        c_q[gi] <= mac_res;
      end
    end
    assign bus.block_c[gi*DATA_W +: DATA_W] = c_q[gi];
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_block_multiply.sv
// Drives three block_multiply configurations (saturating, wrapping, FRAC_W=8)
// with the same directed jobs; a per-DUT monitor pops expected tiles from a queue
// whenever done rises, while the stimulus thread checks timing and reset behaviour.
module tb_block_multiply;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] blk_a;
  logic [63:0] blk_b;

  always #5 clk = ~clk;

  block_multiply_if #(.DATA_W(16), .J(2), .K(2)) if_sat  ();
  block_multiply_if #(.DATA_W(16), .J(2), .K(2)) if_wrap ();
  block_multiply_if #(.DATA_W(16), .J(2), .K(2)) if_frac ();

  assign if_sat.start    = start;
  assign if_sat.block_a  = blk_a;
  assign if_sat.block_b  = blk_b;
  assign if_wrap.start   = start;
  assign if_wrap.block_a = blk_a;
  assign if_wrap.block_b = blk_b;
  assign if_frac.start   = start;
  assign if_frac.block_a = blk_a;
  assign if_frac.block_b = blk_b;

  block_multiply #(.DATA_W(16), .J(2), .K(2), .FRAC_W(0), .SAT(1)) u_sat (
    .clk (clk), .rst (rst), .bus (if_sat.slave)
  );
  block_multiply #(.DATA_W(16), .J(2), .K(2), .FRAC_W(0), .SAT(0)) u_wrap (
    .clk (clk), .rst (rst), .bus (if_wrap.slave)
  );
  block_multiply #(.DATA_W(16), .J(2), .K(2), .FRAC_W(8), .SAT(1)) u_frac (
    .clk (clk), .rst (rst), .bus (if_frac.slave)
  );

  typedef struct {
    string       name;
    logic [63:0] c;
    logic        ovf;
  } exp_t;

  exp_t q_sat[$];
  exp_t q_wrap[$];
  exp_t q_frac[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Element e of a 2x2 tile sits at [e*16 +: 16]
  function automatic logic [63:0] m4(input logic [15:0] e0, input logic [15:0] e1,
                                     input logic [15:0] e2, input logic [15:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic check_job(input string cfg, input logic [63:0] c, input logic ovf, input exp_t e);
    $display("job %s [%s]: block_c=%h overflow=%0b (expect %h / %0b)", e.name, cfg, c, ovf, e.c, e.ovf);
    cmp({e.name, "_", cfg, "_block_c"}, c, e.c);
    cmp({e.name, "_", cfg, "_overflow"}, 64'(ovf), 64'(e.ovf));
  endtask

  task automatic push_exp(input string name,
                          input logic [63:0] c_sat,  input logic o_sat,
                          input logic [63:0] c_wrap, input logic o_wrap,
                          input logic [63:0] c_frac, input logic o_frac);
    exp_t e;
    e.name = name;
    e.c = c_sat;  e.ovf = o_sat;  q_sat.push_back(e);
    e.c = c_wrap; e.ovf = o_wrap; q_wrap.push_back(e);
    e.c = c_frac; e.ovf = o_frac; q_frac.push_back(e);
  endtask

  // Monitors: one check per rising edge of done on each DUT
  logic pd_sat = 1'b0, pd_wrap = 1'b0, pd_frac = 1'b0;

  always @(negedge clk) begin
    if (if_sat.done && !pd_sat) begin
      if (q_sat.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sat_unexpected_done: got done=1, expected no pending job");
      end else begin
        check_job("sat", if_sat.block_c, if_sat.overflow, q_sat.pop_front());
      end
    end
    pd_sat <= if_sat.done;
  end

  always @(negedge clk) begin
    if (if_wrap.done && !pd_wrap) begin
      if (q_wrap.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL wrap_unexpected_done: got done=1, expected no pending job");
      end else begin
        check_job("wrap", if_wrap.block_c, if_wrap.overflow, q_wrap.pop_front());
      end
    end
    pd_wrap <= if_wrap.done;
  end

  always @(negedge clk) begin
    if (if_frac.done && !pd_frac) begin
      if (q_frac.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL frac_unexpected_done: got done=1, expected no pending job");
      end else begin
        check_job("frac", if_frac.block_c, if_frac.overflow, q_frac.pop_front());
      end
    end
    pd_frac <= if_frac.done;
  end

  // Issue one job, scramble the inputs after capture, check latency, optionally hold start
  task automatic run_job(input string name, input logic [63:0] a, input logic [63:0] b,
                         input int hold);
    int edges;
    @(negedge clk);
    blk_a = a;
    blk_b = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    cmp({name, "_busy_on_accept"}, 64'(if_sat.busy), 64'd1);
    blk_a = ~a;
    blk_b = ~b;
    edges = 0;
    while (!if_sat.done && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    cmp({name, "_done_latency"}, 64'(edges), 64'd9);
    cmp({name, "_busy_at_done"}, 64'(if_sat.busy), 64'd0);
    cmp({name, "_frac_done"}, 64'(if_frac.done), 64'd1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      cmp({name, "_done_held"}, 64'(if_sat.done), 64'd1);
      cmp({name, "_no_rerun"}, 64'(if_sat.busy), 64'd0);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    cmp({name, "_done_drop"}, 64'(if_sat.done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    blk_a = '0;
    blk_b = '0;
    repeat (3) @(posedge clk);
    #1;
    cmp("reset_busy",     64'(if_sat.busy),     64'd0);
    cmp("reset_done",     64'(if_sat.done),     64'd0);
    cmp("reset_overflow", 64'(if_sat.overflow), 64'd0);
    cmp("reset_block_c",  if_sat.block_c,       64'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: basic product
    push_exp("t1",
             m4(16'h0013, 16'h0016, 16'h002B, 16'h0032), 1'b0,
             m4(16'h0013, 16'h0016, 16'h002B, 16'h0032), 1'b0,
             m4(16'h0000, 16'h0000, 16'h0000, 16'h0000), 1'b0);
    run_job("t1", m4(16'd1, 16'd2, 16'd3, 16'd4), m4(16'd5, 16'd6, 16'd7, 16'd8), 0);

    // 2: negative operands
    push_exp("t2",
             m4(16'hFFFD, 16'h0004, 16'hFFFB, 16'hFFFA), 1'b0,
             m4(16'hFFFD, 16'h0004, 16'hFFFB, 16'hFFFA), 1'b0,
             m4(16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF), 1'b0);
    run_job("t2", m4(16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF),
                  m4(16'h0003, 16'hFFFC, 16'h0005, 16'h0006), 0);

    // 3: largest positive operands: saturate vs wrap
    push_exp("t3",
             m4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), 1'b1,
             m4(16'h0002, 16'h0002, 16'h0002, 16'h0002), 1'b1,
             m4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), 1'b1);
    run_job("t3", m4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF),
                  m4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), 0);

    // 4: fixed-point identity (exact in Q8.8, out of range at FRAC_W=0)
    push_exp("t4",
             m4(16'h7FFF, 16'h0000, 16'h0000, 16'h8000), 1'b1,
             m4(16'h8000, 16'h0000, 16'h0000, 16'h0000), 1'b1,
             m4(16'h0180, 16'h0000, 16'h0000, 16'hFF00), 1'b0);
    run_job("t4", m4(16'h0100, 16'h0000, 16'h0000, 16'h0100),
                  m4(16'h0180, 16'h0000, 16'h0000, 16'hFF00), 0);

    // 5: start held across done, then a fresh request
    push_exp("t5a",
             m4(16'hFFFD, 16'h0004, 16'hFFFB, 16'hFFFA), 1'b0,
             m4(16'hFFFD, 16'h0004, 16'hFFFB, 16'hFFFA), 1'b0,
             m4(16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF), 1'b0);
    run_job("t5a", m4(16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF),
                   m4(16'h0003, 16'hFFFC, 16'h0005, 16'h0006), 4);
    push_exp("t5b",
             m4(16'h0013, 16'h0016, 16'h002B, 16'h0032), 1'b0,
             m4(16'h0013, 16'h0016, 16'h002B, 16'h0032), 1'b0,
             m4(16'h0000, 16'h0000, 16'h0000, 16'h0000), 1'b0);
    run_job("t5b", m4(16'd1, 16'd2, 16'd3, 16'd4), m4(16'd5, 16'd6, 16'd7, 16'd8), 0);

    // 6: reset in the middle of a saturating job
    @(negedge clk);
    blk_a = m4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    blk_b = m4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    start = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    cmp("t6_overflow_before_rst", 64'(if_sat.overflow), 64'd1);
    cmp("t6_busy_before_rst",     64'(if_sat.busy),     64'd1);
    #2;
    rst = 1'b1;
    #1;
    cmp("t6_rst_busy",          64'(if_sat.busy),     64'd0);
    cmp("t6_rst_done",          64'(if_sat.done),     64'd0);
    cmp("t6_rst_overflow",      64'(if_sat.overflow), 64'd0);
    cmp("t6_rst_block_c",       if_sat.block_c,       64'd0);
    cmp("t6_rst_wrap_block_c",  if_wrap.block_c,      64'd0);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    push_exp("t6",
             m4(16'h0013, 16'h0016, 16'h002B, 16'h0032), 1'b0,
             m4(16'h0013, 16'h0016, 16'h002B, 16'h0032), 1'b0,
             m4(16'h0000, 16'h0000, 16'h0000, 16'h0000), 1'b0);
    run_job("t6", m4(16'd1, 16'd2, 16'd3, 16'd4), m4(16'd5, 16'd6, 16'd7, 16'd8), 0);

    repeat (3) @(posedge clk);
    #1;
    cmp("sat_queue_drained",  64'(q_sat.size()),  64'd0);
    cmp("wrap_queue_drained", 64'(q_wrap.size()), 64'd0);
    cmp("frac_queue_drained", 64'(q_frac.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
